// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-core token arbiter.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arbState_t;

   localparam int NREQ_MAX = 8;

   function automatic int idxWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module vend_rr_pick
   import vend_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idxWidth(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      logic [IW-1:0] cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IW'((int'(ptr) + i) % NREQ);
         if (!any && req_valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/vend_token_arbiter.sv
// Round-robin arbiter sharing one vending core among NREQ token requesters.
// Optional ownership lock is compiled in with VEND_ARB_LOCK_EN.
module vend_token_arbiter
   import vend_pkg::*;
#(
   parameter int  NREQ     = 4,
   parameter int  LOCK_MAX = 4,
   localparam int IW       = idxWidth(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ-1:0] req_t,
   input  logic [NREQ-1:0] req_lock,
   output logic [NREQ-1:0] req_ready,
   output logic [NREQ-1:0] rsp_valid,
   output logic            rsp_a,
   output logic            rsp_p,
   output logic            vm_en,
   output logic            vm_t,
   input  logic            vm_a,
   input  logic            vm_p,
   output logic            busy,
   output logic [IW-1:0]   owner
);

   if (NREQ < 1 || NREQ > NREQ_MAX) begin : g_badNreq
      $error("vend_token_arbiter: NREQ out of range");
   end

   arbState_t       r_state;
   arbState_t       w_next;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;
   logic            r_tok;
   logic            r_a;
   logic            r_p;
   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_idx;
   logic            w_any;
   logic [IW-1:0]   w_ownerNext;
   logic [IW-1:0]   w_ptrNext;

   vend_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .idx       (w_idx),
      .any       (w_any)
   );

   assign w_ownerNext = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef VEND_ARB_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX + 1);

   logic [CW-1:0] r_lockCnt;
   logic          w_lockHold;

   assign w_lockHold = req_lock[r_owner] && (r_lockCnt < CW'(LOCK_MAX));
   assign w_ptrNext  = w_lockHold ? r_owner : w_ownerNext;

   // Count consecutive locked transactions; any change of owner restarts the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lockCnt <= '0;
      end else if (r_state == ST_IDLE && w_any && w_idx != r_owner) begin
         r_lockCnt <= '0;
      end else if (r_state == ST_RESP) begin
         r_lockCnt <= w_lockHold ? r_lockCnt + 1'b1 : '0;
      end
   end
`else
   logic w_unusedLock;

   assign w_unusedLock = ^{req_lock, (LOCK_MAX > 0)};
   assign w_ptrNext    = w_ownerNext;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // req_ready is forced low during reset so every output reads zero immediately.
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      rsp_valid = '0;
      vm_en     = 1'b0;
      vm_t      = 1'b0;
      busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_next = ST_ISSUE;
            end
            if (!rst) begin
               req_ready = w_grant;
            end
         end
         ST_ISSUE: begin
            w_next = ST_RESP;
            vm_en  = 1'b1;
            vm_t   = r_tok;
            busy   = 1'b1;
         end
         ST_RESP: begin
            w_next    = ST_IDLE;
            rsp_valid = NREQ'(1) << r_owner;
            busy      = 1'b1;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_tok   <= 1'b0;
         r_a     <= 1'b0;
         r_p     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner <= w_idx;
                  r_tok   <= req_t[w_idx];
               end
            end
            ST_ISSUE: begin
               r_a <= vm_a;
               r_p <= vm_p;
            end
            ST_RESP: begin
               r_ptr <= w_ptrNext;
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_a = r_a;
   assign rsp_p = r_p;
   assign owner = r_owner;

endmodule

// File: tb/tb_vend_token_arbiter.sv
// Directed-vector bench for vend_token_arbiter with a small stand-in vending core.
module tb_vend_token_arbiter;

   localparam logic B0 = 1'b0;
   localparam logic B1 = 1'b1;
   localparam logic [3:0] Z4 = 4'h0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_valid = 4'h0;
   logic [3:0] req_t = 4'h0;
   logic [3:0] req_lock = 4'h0;
   logic [3:0] req_ready;
   logic [3:0] rsp_valid;
   logic       rsp_a;
   logic       rsp_p;
   logic       vm_en;
   logic       vm_t;
   logic       busy;
   logic [1:0] owner;

   logic       coreClr = 1'b0;
   logic [1:0] coreState = 2'd0;
   logic [1:0] coreNext;
   logic       vmA;
   logic       vmP;

   int nVec = 0;
   int nMiss = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] valid;
      logic [3:0] tok;
      logic [3:0] lock;
      logic       clr;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   vend_token_arbiter #(
      .NREQ     (4),
      .LOCK_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_t     (req_t),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_a     (rsp_a),
      .rsp_p     (rsp_p),
      .vm_en     (vm_en),
      .vm_t      (vm_t),
      .vm_a      (vmA),
      .vm_p      (vmP),
      .busy      (busy),
      .owner     (owner)
   );

   // Stand-in Mealy core: T=1 walks S0..S3, T=0 returns to S0.
   always_comb begin
      vmA      = 1'b0;
      vmP      = 1'b0;
      coreNext = 2'd0;
      if (vm_t) begin
         case (coreState)
            2'd0:    {vmA, vmP, coreNext} = {1'b1, 1'b1, 2'd1};
            2'd1:    {vmA, vmP, coreNext} = {1'b1, 1'b0, 2'd2};
            2'd2:    {vmA, vmP, coreNext} = {1'b0, 1'b0, 2'd3};
            default: {vmA, vmP, coreNext} = {1'b0, 1'b1, 2'd0};
         endcase
      end else if (coreState != 2'd0) begin
         {vmA, vmP} = 2'b11;
      end
   end

   always @(posedge clk) begin
      if (coreClr) begin
         coreState <= 2'd0;
      end else if (vm_en) begin
         coreState <= coreNext;
      end
   end

   function automatic logic [14:0] dutOut();
      return {req_ready, rsp_valid, vm_en, vm_t, busy, owner, rsp_a, rsp_p};
   endfunction

   task automatic addVec(input string nm, input logic r, input logic [3:0] v, input logic [3:0] t,
                         input logic [3:0] l, input logic c, input logic [3:0] rdy,
                         input logic [3:0] rv, input logic en, input logic vt, input logic bz,
                         input logic [1:0] ow, input logic a, input logic p);
      vec_t x;
      x.name  = nm;
      x.rst   = r;
      x.valid = v;
      x.tok   = t;
      x.lock  = l;
      x.clr   = c;
      x.exp   = {rdy, rv, en, vt, bz, ow, a, p};
      vecs.push_back(x);
   endtask

   // One full transaction: accept, issue, response cycles.
   task automatic addTxn(input string nm, input logic [3:0] v, input logic [3:0] l, input logic [1:0] g,
                         input logic [1:0] prevOw, input logic prevA, input logic prevP,
                         input logic T, input logic A, input logic P);
      logic [3:0] oh;
      logic [3:0] tk;
      oh = 4'b0001 << g;
      tk = T ? oh : Z4;
      addVec({nm, "/acc"}, B0, v, tk, l, B0, oh, Z4, B0, B0, B0, prevOw, prevA, prevP);
      addVec({nm, "/iss"}, B0, v, tk, l, B0, Z4, Z4, B1, T,  B1, g,      prevA, prevP);
      addVec({nm, "/rsp"}, B0, v, tk, l, B0, Z4, oh, B0, B0, B1, g,      A,     P);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      req_valid = v.valid;
      req_t     = v.tok;
      req_lock  = v.lock;
      coreClr   = v.clr;
   endtask

   task automatic checkOutput(input string nm, input logic [14:0] got, input logic [14:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %b, expected %b", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A request raised only during ISSUE must never be granted or answered.
   task automatic droppedSequence();
      req_valid = 4'b0001;
      req_t     = Z4;
      req_lock  = Z4;
      coreClr   = B0;
      @(negedge clk);
      checkOutput("drop/acc0", 15'(req_ready), 15'(4'b0001));
      step();
      req_valid = 4'b0100;
      @(negedge clk);
      checkOutput("drop/issue", 15'({req_ready, vm_en}), 15'({4'b0000, 1'b1}));
      step();
      req_valid = Z4;
      @(negedge clk);
      checkOutput("drop/rsp0", 15'(rsp_valid), 15'(4'b0001));
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         checkOutput("drop/none", 15'({req_ready[2], rsp_valid[2], busy}), 15'(3'b000));
      end
      step();
   endtask

   // Reset asserted in the middle of ISSUE drops the transaction and restarts the pointer.
   task automatic resetSequence();
      req_valid = 4'b0010;
      @(negedge clk);
      checkOutput("rst/acc1", 15'(req_ready), 15'(4'b0010));
      step();
      req_valid = Z4;
      step();
      step();
      req_valid = 4'b0100;
      @(negedge clk);
      checkOutput("rst/acc2", 15'(req_ready), 15'(4'b0100));
      step();
      checkOutput("rst/issue", 15'({vm_en, busy, owner}), 15'({1'b1, 1'b1, 2'd2}));
      #2;
      rst       = B1;
      req_valid = 4'b1111;
      #1;
      checkOutput("rst/async", dutOut(), 15'd0);
      step();
      step();
      rst = B0;
      @(negedge clk);
      checkOutput("rst/first", 15'({req_ready, owner, busy}), 15'({4'b0001, 2'd0, 1'b0}));
      step();
      req_valid = Z4;
      @(negedge clk);
      checkOutput("rst/issue0", 15'({vm_en, owner}), 15'({1'b1, 2'd0}));
      step();
      @(negedge clk);
      checkOutput("rst/rsp0", 15'(rsp_valid), 15'(4'b0001));
      step();
   endtask

   initial begin
      addVec("reset", B1, Z4, Z4, Z4, B1, Z4, Z4, B0, B0, B0, 2'd0, B0, B0);
      addVec("idle",  B0, Z4, Z4, Z4, B0, Z4, Z4, B0, B0, B0, 2'd0, B0, B0);
      addTxn("single", 4'b0001, Z4, 2'd0, 2'd0, B0, B0, B1, B1, B1);
      addVec("coreclr", B0, Z4, Z4, Z4, B1, Z4, Z4, B0, B0, B0, 2'd0, B1, B1);
      addTxn("tok1", 4'b0100, Z4, 2'd2, 2'd0, B1, B1, B1, B1, B1);
      addTxn("tok2", 4'b0100, Z4, 2'd2, 2'd2, B1, B1, B1, B1, B0);
      addTxn("tok3", 4'b0100, Z4, 2'd2, 2'd2, B1, B0, B1, B0, B0);
      addTxn("tok4", 4'b0100, Z4, 2'd2, 2'd2, B0, B0, B0, B1, B1);
      addVec("reset2", B1, 4'b1111, Z4, Z4, B1, Z4, Z4, B0, B0, B0, 2'd0, B0, B0);
      addTxn("fair0", 4'b1111, Z4, 2'd0, 2'd0, B0, B0, B0, B0, B0);
      addTxn("fair1", 4'b1111, Z4, 2'd1, 2'd0, B0, B0, B0, B0, B0);
      addTxn("fair2", 4'b1111, Z4, 2'd2, 2'd1, B0, B0, B0, B0, B0);
      addTxn("fair3", 4'b1111, Z4, 2'd3, 2'd2, B0, B0, B0, B0, B0);
      addTxn("fair4", 4'b1111, Z4, 2'd0, 2'd3, B0, B0, B0, B0, B0);
`ifdef VEND_ARB_LOCK_EN
      addTxn("lock0", 4'b1010, 4'b0010, 2'd1, 2'd0, B0, B0, B0, B0, B0);
      addTxn("lock1", 4'b1010, 4'b0010, 2'd1, 2'd1, B0, B0, B0, B0, B0);
      addTxn("lock2", 4'b1010, 4'b0010, 2'd1, 2'd1, B0, B0, B0, B0, B0);
      addTxn("lock3", 4'b1010, 4'b0010, 2'd1, 2'd1, B0, B0, B0, B0, B0);
      addTxn("lock4", 4'b1010, 4'b0010, 2'd1, 2'd1, B0, B0, B0, B0, B0);
      addTxn("lock5", 4'b1010, 4'b0010, 2'd3, 2'd1, B0, B0, B0, B0, B0);
`else
      addTxn("rr0", 4'b1010, 4'b0010, 2'd1, 2'd0, B0, B0, B0, B0, B0);
      addTxn("rr1", 4'b1010, 4'b0010, 2'd3, 2'd1, B0, B0, B0, B0, B0);
      addTxn("rr2", 4'b1010, 4'b0010, 2'd1, 2'd3, B0, B0, B0, B0, B0);
      addTxn("rr3", 4'b1010, 4'b0010, 2'd3, 2'd1, B0, B0, B0, B0, B0);
`endif
      addVec("idleEnd", B0, Z4, Z4, Z4, B0, Z4, Z4, B0, B0, B0, 2'd3, B0, B0);

      rst = B1;
      step();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i].name, dutOut(), vecs[i].exp);
         step();
      end

      droppedSequence();
      resetSequence();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/vend_token_arbiter.md
# vend_token_arbiter

Shares one vending-machine core between `NREQ` token requesters. Each accepted request becomes exactly one token step on the core. The arbiter drives the core's token input and step enable, captures the core's accept/pay outputs, and returns them to the winning requester. It sits between the front-panel/coin-slot channels and the vending FSM core, which advances only on cycles where `vm_en` = 1.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..8.
- `LOCK_MAX`, 4: maximum consecutive locked transactions per owner, ≥1. Used only with `VEND_ARB_LOCK_EN`.

Ports (`IW` = max(1, clog2(NREQ))):
- `clk` in 1: the single clock. Everything is clocked on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester request. Held until `req_ready`.
- `req_t` in NREQ: per-requester token value.
- `req_lock` in NREQ: request to keep ownership for the next transaction.
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse.
- `rsp_a` out 1: captured core A. Valid while any `rsp_valid` bit is high.
- `rsp_p` out 1: captured core P. Valid while any `rsp_valid` bit is high.
- `vm_en` out 1: core step enable.
- `vm_t` out 1: core token input.
- `vm_a` in 1: core A (Mealy output, combinational on `vm_t`).
- `vm_p` in 1: core P (Mealy output, combinational on `vm_t`).
- `busy` out 1: high in ISSUE and RESP.
- `owner` out IW: index of the last granted requester.

## Operation
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: the picker selects a winner combinationally from `req_valid`. If any request is present, `req_ready[w]` = 1 this cycle, the arbiter latches `w` into `owner` and `req_t[w]` into `tok_q`, and moves to ISSUE. Otherwise it stays in IDLE.
  - ISSUE: `vm_en` = 1 and `vm_t` = `tok_q`. The arbiter samples `vm_a`/`vm_p` into `a_q`/`p_q` at the clock edge, then moves to RESP.
  - RESP: `rsp_valid[owner]` = 1, `rsp_a` = `a_q`, `rsp_p` = `p_q`. The arbiter updates the pointer, then moves to IDLE.
- Round-robin pointer `ptr`:
  - Search order is `ptr`, `ptr`+1, …, wrapping modulo NREQ.
  - After RESP, `ptr` = `owner`+1 modulo NREQ. Wrap from NREQ-1 goes to 0.
- Outside ISSUE: `vm_en` = 0 and `vm_t` = 0.
- Outside RESP: `rsp_valid` = 0. `rsp_a`/`rsp_p` hold their last values.
- A request dropped before its `req_ready` is legal. It is not granted and leaves no state.
- `vm_a`/`vm_p` are ignored outside ISSUE.
- NREQ = 1: the pointer is constant 0, and a requester holding `req_valid` is served every 3 cycles.
- Reset (any time, including mid-transaction):
  - FSM → IDLE, `ptr` = 0, `owner` = 0, `tok_q`/`a_q`/`p_q` = 0, lock count = 0.
  - All outputs are 0 immediately. An in-flight transaction is dropped with no response.
  - Core state is not touched; the core has its own reset.

## Timing
- Accept (`req_ready`) in cycle N → `vm_en` in N+1 → `rsp_valid` in N+2.
- Next earliest accept is N+3. Peak throughput is one token per 3 cycles.
- `req_ready` depends combinationally on `req_valid` (IDLE only). No other input-to-output combinational path exists.
- `vm_t` and `vm_en` are register-driven.

## Configuration
- `VEND_ARB_LOCK_EN` defined:
  - If `req_lock[owner]` = 1 in RESP and the lock count < `LOCK_MAX`, `ptr` stays at `owner`, giving the owner first priority in the next IDLE.
  - The lock count increments per locked transaction.
  - The count clears when the owner changes or `req_lock[owner]` = 0.
  - When the count reaches `LOCK_MAX`, rotation is forced (`ptr` = `owner`+1) and the count clears.
- `VEND_ARB_LOCK_EN` undefined:
  - `req_lock` is ignored and `LOCK_MAX` is unused; behaviour is pure round-robin.
  - No lock-count logic is compiled in.

## Structure
- Shared package `vend_pkg` holds:
  - the FSM state enum (IDLE/ISSUE/RESP);
  - the NREQ upper bound (8);
  - the IW width constant/function.
- One sub-module, `vend_rr_pick`:
  - inputs: `req_valid` and `ptr`;
  - outputs: one-hot grant, winner index, and an any-request flag;
  - purely combinational.

## Test plan
- Reset, idle, single request:
  - Reset, then `req_valid`=0001 with `req_t[0]`=1.
  - `req_ready`=0001 at N; `vm_en`=1 with `vm_t`=1 at N+1; `rsp_valid`=0001 at N+2.
  - `rsp_a`/`rsp_p` equal the core's A/P for T=1 from the model state (S0 → A=1, P=1).
- Fairness and wrap:
  - All four requesters held valid.
  - Grants are 0, 1, 2, 3, 0, spaced exactly 3 cycles apart; `ptr` wraps 3 → 0.
- Token sequence:
  - Requester 2 issues T = 1, 1, 1, 0 with the core from S0.
  - Responses (A, P) = (1,1), (1,0), (0,0), (1,1).
- Reset mid-transaction:
  - Assert `rst` during ISSUE.
  - `vm_en`, `req_ready` and `rsp_valid` go to 0 asynchronously; no response is issued.
  - After release, the first grant is to requester 0 (`ptr` = 0).
- Lock (`VEND_ARB_LOCK_EN`, `LOCK_MAX`=4):
  - Requesters 1 and 3 valid; requester 1 holds `req_lock`.
  - Grants are 1, 1, 1, 1, 1, then 3. That is the initial grant plus 4 locked repeats, after which rotation is forced.
  - Without the macro: grants alternate 1, 3, 1, 3.
- Dropped request:
  - `req_valid[2]` pulses for one cycle while the arbiter is in ISSUE.
  - No `req_ready[2]` and no `rsp_valid[2]` ever occur.
